// File: rtl/drive_mode_sequencer_pkg.sv
// Shared gear codes, FSM state encoding and reject reasons for the drive
// mode sequencer, vehicle physics block and keypad decoder.
package drive_mode_sequencer_pkg;

  localparam logic [3:0] GEAR_P = 4'd3;
  localparam logic [3:0] GEAR_R = 4'd6;
  localparam logic [3:0] GEAR_N = 4'd9;
  localparam logic [3:0] GEAR_D = 4'd12;

  localparam logic [2:0] REJ_NONE        = 3'd0;
  localparam logic [2:0] REJ_CRANK_PRE   = 3'd1;
  localparam logic [2:0] REJ_CRANK_ABORT = 3'd2;
  localparam logic [2:0] REJ_STOP_PRE    = 3'd3;
  localparam logic [2:0] REJ_BAD_GEAR    = 3'd4;
  localparam logic [2:0] REJ_INTERLOCK   = 3'd5;
  localparam logic [2:0] REJ_STALL       = 3'd6;
  localparam logic [2:0] REJ_BUSY        = 3'd7;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_CRANK = 2'd1,
    S_RUN   = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  function automatic logic gear_ok(input logic [3:0] g);
    return (g == GEAR_P) || (g == GEAR_R) ||
           (g == GEAR_N) || (g == GEAR_D);
  endfunction

  function automatic logic park_or_neutral(input logic [3:0] g);
    return (g == GEAR_P) || (g == GEAR_N);
  endfunction

  function automatic logic rd_swap(input logic [3:0] a,
                                   input logic [3:0] b);
    return ((a == GEAR_R) && (b == GEAR_D)) ||
           ((a == GEAR_D) && (b == GEAR_R));
  endfunction

endpackage

// File: rtl/drive_mode_sequencer_tick_countdown.sv
// Loadable down-counter stepped by a tick pulse; saturates at zero.
// done also fires on the tick that takes the count from 1 to 0.
module tick_countdown #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0) |
                (en & (count == W'(1)));

endmodule

// File: rtl/drive_mode_sequencer.sv
// Engine start/stop and P/R/N/D sequencing with brake, speed and fuel
// interlocks; drives the vehicle physics block.
import drive_mode_sequencer_pkg::*;

module drive_mode_sequencer #(
  parameter int CRANK_TICKS = 2,
  parameter int SHIFT_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1sec,
  input  logic       tick_speed,
  input  logic       btn_start,
  input  logic       gear_req_valid,
  input  logic [3:0] gear_req,
  input  logic       is_brake_normal,
  input  logic       is_brake_hard,
  input  logic [7:0] speed,
  input  logic [7:0] fuel,
  output logic       engine_on,
  output logic [3:0] current_gear,
  output logic       crank_active,
  output logic       shift_busy,
  output logic       req_reject,
  output logic [2:0] reject_code
);

  localparam logic [3:0] CRANK_LD = 4'(CRANK_TICKS);
  localparam logic [3:0] SHIFT_LD = 4'(SHIFT_TICKS);

  state_t     state_q, state_d;
  logic [3:0] gear_d;
  logic [3:0] target_q, target_d;
  logic       rej_d;
  logic [2:0] code_d;
  logic       crank_load, shift_load;
  logic       crank_done, shift_done;
  logic       brake, stopped, dry;

  assign brake   = is_brake_normal | is_brake_hard;
  assign stopped = (speed == 8'd0);
  assign dry     = (fuel == 8'd0);

  tick_countdown #(.W(4)) u_crank_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (crank_load),
    .load_val (CRANK_LD),
    .en       (tick_1sec & (state_q == S_CRANK)),
    .done     (crank_done)
  );

  tick_countdown #(.W(4)) u_shift_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (shift_load),
    .load_val (SHIFT_LD),
    .en       (tick_speed & (state_q == S_SHIFT)),
    .done     (shift_done)
  );

  always_comb begin
    state_d    = state_q;
    gear_d     = current_gear;
    target_d   = target_q;
    rej_d      = 1'b0;
    code_d     = reject_code;
    crank_load = 1'b0;
    shift_load = 1'b0;
    unique case (state_q)
      S_OFF: begin
        if (btn_start) begin
          if (brake && park_or_neutral(current_gear) && !dry) begin
            state_d    = S_CRANK;
            crank_load = 1'b1;
            if (gear_req_valid) begin
              rej_d  = 1'b1;
              code_d = REJ_BUSY;
            end
          end else begin
            rej_d  = 1'b1;
            code_d = REJ_CRANK_PRE;
          end
        end else if (gear_req_valid) begin
          rej_d  = 1'b1;
          code_d = REJ_BUSY;
        end
      end
      S_CRANK: begin
        // Releasing the brake aborts even on the completing tick
        if (!brake) begin
          state_d = S_OFF;
          rej_d   = 1'b1;
          code_d  = REJ_CRANK_ABORT;
        end else begin
          if (crank_done) state_d = S_RUN;
          if (btn_start || gear_req_valid) begin
            rej_d  = 1'b1;
            code_d = REJ_BUSY;
          end
        end
      end
      S_RUN: begin
        if (dry) begin
          state_d = S_OFF;
          rej_d   = 1'b1;
          code_d  = REJ_STALL;
        end else if (btn_start) begin
          if (stopped && park_or_neutral(current_gear)) begin
            state_d = S_OFF;
            if (gear_req_valid) begin
              rej_d  = 1'b1;
              code_d = REJ_BUSY;
            end
          end else begin
            rej_d  = 1'b1;
            code_d = REJ_STOP_PRE;
          end
        end else if (gear_req_valid) begin
          if (!gear_ok(gear_req)) begin
            rej_d  = 1'b1;
            code_d = REJ_BAD_GEAR;
          end else if (gear_req != current_gear) begin
            if (current_gear == GEAR_P && !brake) begin
              rej_d  = 1'b1;
              code_d = REJ_INTERLOCK;
            end else if (!stopped &&
                         ((gear_req == GEAR_P) ||
                          rd_swap(current_gear, gear_req))) begin
              rej_d  = 1'b1;
              code_d = REJ_INTERLOCK;
            end else begin
              target_d   = gear_req;
              gear_d     = GEAR_N;
              shift_load = 1'b1;
              state_d    = S_SHIFT;
            end
          end
        end
      end
      S_SHIFT: begin
        if (dry) begin
          state_d = S_OFF;
          gear_d  = GEAR_N;
          rej_d   = 1'b1;
          code_d  = REJ_STALL;
        end else begin
          if (shift_done) begin
            state_d = S_RUN;
            gear_d  = target_q;
          end
          if (btn_start || gear_req_valid) begin
            rej_d  = 1'b1;
            code_d = REJ_BUSY;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_OFF;
      target_q     <= GEAR_P;
      engine_on    <= 1'b0;
      current_gear <= GEAR_P;
      crank_active <= 1'b0;
      shift_busy   <= 1'b0;
      req_reject   <= 1'b0;
      reject_code  <= REJ_NONE;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      engine_on    <= (state_d == S_RUN) ||
                      (state_d == S_SHIFT);
      current_gear <= gear_d;
      crank_active <= (state_d == S_CRANK);
      shift_busy   <= (state_d == S_SHIFT);
      req_reject   <= rej_d;
      reject_code  <= code_d;
    end
  end

endmodule

// File: doc/drive_mode_sequencer.md
Name: drive_mode_sequencer

Overview:
- Sequences engine start/stop and P/R/N/D gear selection for the vehicle physics block.
- Drives that block's engine_on and current_gear inputs.
- Consumes its speed and fuel outputs for interlocks and stall detection.
- Sits between keypad/button decode and the vehicle physics block. Owns all safety interlocks: brake-to-start, zero-speed for P and R<->D shifts, fuel stall.

Parameters:
- CRANK_TICKS, 2, tick_1sec pulses spent cranking before engine_on asserts (1..15).
- SHIFT_TICKS, 4, tick_speed pulses spent in neutral during a gear change (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- tick_1sec  in  1  1-cycle pulse, 1 Hz
- tick_speed  in  1  1-cycle pulse, physics update rate
- btn_start  in  1  1-cycle start/stop request (already debounced)
- gear_req_valid  in  1  1-cycle gear request strobe
- gear_req  in  4  requested gear code: 3=P, 6=R, 9=N, 12=D
- is_brake_normal  in  1  service brake pressed
- is_brake_hard  in  1  hard brake pressed
- speed  in  8  current speed, km/h
- fuel  in  8  fuel percent
- engine_on  out  1  engine running
- current_gear  out  4  applied gear code
- crank_active  out  1  high while cranking
- shift_busy  out  1  high while a shift is in progress
- req_reject  out  1  1-cycle pulse when a request is refused or a stall occurs
- reject_code  out  3  reason, valid with req_reject; holds its last value otherwise

Behaviour:
- Reset values (rst=0, async): state=OFF, engine_on=0, current_gear=3, crank_active=0, shift_busy=0, req_reject=0, reject_code=0, counters=0.
- brake = is_brake_normal | is_brake_hard.
- Reject codes: 1 crank precondition, 2 crank abort, 3 stop precondition, 4 invalid gear code, 5 interlock, 6 fuel stall, 7 busy/not running/collision.
- All outputs are registered. Decisions use input values sampled at the clock edge and take effect on the next cycle.
- FSM states: OFF, CRANK, RUN, SHIFT.
- OFF:
  - btn_start with brake, gear in {3,9} and fuel>0 -> CRANK, counter=CRANK_TICKS.
  - Otherwise btn_start -> reject 1.
  - gear_req_valid -> reject 7.
- CRANK:
  - crank_active=1.
  - Counter decrements on tick_1sec. At 0 -> RUN, engine_on=1.
  - Brake released before completion -> OFF, reject 2.
  - btn_start or gear_req_valid -> reject 7.
- RUN, btn_start:
  - speed==0 and gear in {3,9} -> OFF, engine_on=0.
  - Otherwise reject 3.
- RUN, gear_req_valid, checked in this order:
  - Code not in {3,6,9,12} -> reject 4.
  - Equal to current_gear -> ignored; no reject, no shift.
  - Leaving P without brake -> reject 5.
  - Target P, or R<->D in either direction, with speed!=0 -> reject 5.
  - Otherwise latch target, current_gear=9, shift_busy=1, counter=SHIFT_TICKS, go to SHIFT.
- SHIFT:
  - Counter decrements on tick_speed. At 0 -> current_gear=target, shift_busy=0, RUN.
  - Any btn_start or gear_req_valid -> reject 7.
- Fuel stall: fuel==0 in RUN or SHIFT -> OFF next cycle, engine_on=0, reject 6.
  - From RUN, current_gear is unchanged.
  - From SHIFT, current_gear=9 and shift_busy=0.
  - Stall takes priority over every other event in the same cycle.
- Simultaneous btn_start and gear_req_valid: btn_start is processed and the gear request is rejected with 7. req_reject still pulses once.
- Tick coincident with counter==1 completes on that cycle. A counter at 0 never wraps.
- rst asserted mid-crank or mid-shift: immediate return to reset values, current_gear=3.

Decomposition:
- Shared package holds:
  - gear codes GEAR_P=4'd3, GEAR_R=4'd6, GEAR_N=4'd9, GEAR_D=4'd12
  - FSM state encoding
  - REJ_* reason constants
- The vehicle physics block and the keypad decoder import the same gear constants.
- One sub-module, tick_countdown: load value, decrement on enable pulse, saturate at 0, done flag. It is instantiated twice, once for crank (tick_1sec) and once for shift (tick_speed).

Test Plan:
- Reset, brake=1, btn_start, 2 tick_1sec -> crank_active for 2 ticks, then engine_on=1, current_gear=3.
- OFF, brake=0, btn_start -> req_reject=1 with code 1, engine_on stays 0. Separately, brake released after 1 tick_1sec of crank -> state OFF, code 2.
- RUN in P, brake=1, request D -> current_gear=9 with shift_busy=1 for 4 tick_speed pulses, then current_gear=12.
- In D with speed=40, request R -> code 5, gear stays 12. Same with speed=0 -> shift completes to 6.
- In D with speed=40, fuel drops to 0 -> engine_on=0 next cycle, code 6, gear stays 12. Mid-shift stall -> current_gear=9.
- Request during SHIFT -> code 7. Request gear_req=5 -> code 4. btn_start in D -> code 3. btn_start with speed=0 in N -> engine_on=0.
